// File: rtl/clear_lines_if.sv
// Handshake and data bundle between the field-merge stage and clear_lines.
// field vectors are row-major: cell (r,x) sits at bits [(r*COLS+x)*IDX_W +: IDX_W].
interface clear_lines_if #(
    parameter int ROWS  = 22,
    parameter int COLS  = 10,
    parameter int IDX_W = 3
);
    localparam int FW = ROWS * COLS * IDX_W;
    localparam int LW = $clog2(ROWS + 1);

    logic          start;
    logic [FW-1:0] field_in;
    logic          busy;
    logic          done;
    logic [FW-1:0] field_out;
    logic [LW-1:0] lines_cleared;

    modport master (
        output start, field_in,
        input  busy, done, field_out, lines_cleared
    );

    modport slave (
        input  start, field_in,
        output busy, done, field_out, lines_cleared
    );
endinterface

// File: rtl/clear_lines.sv
// Sequential line-clear engine: scans a locked field bottom-up,
// drops full rows and reports how many rows were removed.
module clear_lines #(
    parameter int              ROWS      = 22,
    parameter int              COLS      = 10,
    parameter int              IDX_W     = 3,
    parameter logic [IDX_W-1:0] EMPTY_IDX = 3'b111
) (
    input logic           clk,
    input logic           reset,
    clear_lines_if.slave  bus
);
    localparam int FW = ROWS * COLS * IDX_W;
    localparam int LW = $clog2(ROWS + 1);
    localparam int YW = $clog2(ROWS);
    localparam int RW = COLS * IDX_W;

    localparam logic [RW-1:0] EMPTY_ROW = {COLS{EMPTY_IDX}};
    localparam logic [FW-1:0] EMPTY_FLD = {(ROWS * COLS){EMPTY_IDX}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [FW-1:0] buf_q;
    logic [FW-1:0] shifted;
    logic [YW-1:0] y;
    logic [LW-1:0] lines;
    logic [RW-1:0] cur_row;
    logic          row_full;

    assign cur_row = buf_q[y*RW +: RW];

    always_comb begin
        row_full = 1'b1;
        for (int x = 0; x < COLS; x++) begin
            if (cur_row[x*IDX_W +: IDX_W] == EMPTY_IDX) begin
                row_full = 1'b0;
            end
        end
    end

    // Rows 1..y take the row above; rows below y are untouched.
    always_comb begin
        shifted = buf_q;
        shifted[RW-1:0] = EMPTY_ROW;
        for (int r = 1; r < ROWS; r++) begin
            if (r <= 32'(y)) begin
                shifted[r*RW +: RW] = buf_q[(r-1)*RW +: RW];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_nx = SHIFT;
                end else if (y == '0) begin
                    state_nx = DONE;
                end
            end
            SHIFT:   state_nx = SCAN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            buf_q <= EMPTY_FLD;
            y     <= YW'(ROWS - 1);
            lines <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        buf_q <= bus.field_in;
                        y     <= YW'(ROWS - 1);
                        lines <= '0;
                    end
                end
                SCAN: begin
                    if (!row_full && y != '0) begin
                        y <= y - 1'b1;
                    end
                end
                SHIFT: begin
                    buf_q <= shifted;
                    lines <= lines + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.field_out     = buf_q;
    assign bus.lines_cleared = lines;
endmodule
